// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and constants for the UART command parser.
// The ECHO state exists only when UART_CMD_PARSER_ECHO_EN is defined.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_GAP,
`ifdef UART_CMD_PARSER_ECHO_EN
      S_ECHO,
`endif
      S_CHECK,
      S_RESP
   } state_t;

   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;

   localparam int unsigned CMD_TEST_LEN = 4;
   localparam logic [8*CMD_TEST_LEN-1:0] CMD_TEST = 32'h54455354; // "TEST"

   localparam int unsigned RESP_LEN = 6;
   typedef logic [0:RESP_LEN-1][7:0] resp_t;
   localparam resp_t RESP_PASS = {8'h50, 8'h41, 8'h53, 8'h53, 8'h0D, 8'h0A};
   localparam resp_t RESP_FAIL = {8'h46, 8'h41, 8'h49, 8'h4C, 8'h0D, 8'h0A};

   // Byte idx of "TEST", first character at idx 0; out-of-range gives 0.
   function automatic logic [7:0] cmd_test_byte(input int unsigned idx);
      if (idx >= CMD_TEST_LEN) return 8'h00;
      return CMD_TEST[8*(CMD_TEST_LEN-1-idx) +: 8];
   endfunction

endpackage

// File: rtl/uart_cmd_parser_resp_streamer.sv
// resp_streamer: streams the selected 6-byte reply into the TX FIFO,
// one byte per non-full cycle; o_done marks the cycle of the last write.
module resp_streamer
   import uart_cmd_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       i_load,
   input  logic       i_pass,
   input  logic       i_full,
   output logic [7:0] o_data,
   output logic       o_wr_en,
   output logic       o_done
);

   localparam logic [2:0] LAST_IDX = 3'(RESP_LEN - 1);

   logic       r_active;
   logic       r_sel_pass;
   logic [2:0] r_idx;
   logic [7:0] w_byte;

   // Reply selection, byte index and backpressure hold
   always_ff @(posedge clock) begin
      if (reset) begin
         r_active   <= 1'b0;
         r_sel_pass <= 1'b0;
         r_idx      <= '0;
      end else if (i_load) begin
         r_active   <= 1'b1;
         r_sel_pass <= i_pass;
         r_idx      <= '0;
      end else if (r_active && !i_full) begin
         if (r_idx == LAST_IDX) r_active <= 1'b0;
         else                   r_idx    <= r_idx + 1'b1;
      end
   end

   // Current reply byte
   always_comb begin
      w_byte = r_sel_pass ? RESP_PASS[r_idx] : RESP_FAIL[r_idx];
   end

   assign o_wr_en = r_active & ~i_full;
   assign o_data  = r_active ? w_byte : '0;
   assign o_done  = o_wr_en & (r_idx == LAST_IDX);

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: pops RX bytes, assembles a CR-terminated command,
// matches it against "TEST" and streams "PASS\r\n" / "FAIL\r\n" to TX.
// Optional: UART_CMD_PARSER_ECHO_EN echoes every popped byte to TX.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int unsigned CMD_LEN   = 4,
   parameter logic [7:0]  TERM_CHAR = CHAR_CR,
   parameter logic [7:0]  SKIP_CHAR = CHAR_LF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_fifo_empty,
   input  logic [7:0] rx_fifo_data_out,
   output logic       rx_fifo_read_en,
   input  logic       tx_fifo_full,
   output logic [7:0] tx_fifo_data_in,
   output logic       tx_fifo_write_en,
   output logic       cmd_pass,
   output logic       cmd_fail,
   output logic       busy
);

   localparam int unsigned CW = $clog2(CMD_LEN + 1);

   state_t                 r_state;
   logic                   r_term;
   logic [CW-1:0]          r_count;
   logic                   r_ovf;
   logic [8*CMD_LEN-1:0]   r_buf;
   logic                   r_rd_en;
   logic                   r_pass;
   logic                   r_fail;
`ifdef UART_CMD_PARSER_ECHO_EN
   logic [7:0]             r_byte;
`endif

   logic                   w_match;
   logic                   w_load;
   logic [7:0]             w_str_data;
   logic                   w_str_wr;
   logic                   w_str_done;

   // Command match: exact length, no overflow, bytes equal "TEST"
   always_comb begin
      w_match = (r_count == CW'(CMD_LEN)) && !r_ovf && (CMD_LEN == CMD_TEST_LEN);
      for (int unsigned i = 0; i < CMD_LEN; i++) begin
         if (r_buf[8*i +: 8] != cmd_test_byte(i)) w_match = 1'b0;
      end
   end

   // Main FSM: capture/classify, single pop, dead cycle, check, reply
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_term  <= 1'b0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_buf   <= '0;
         r_rd_en <= 1'b0;
         r_pass  <= 1'b0;
         r_fail  <= 1'b0;
`ifdef UART_CMD_PARSER_ECHO_EN
         r_byte  <= '0;
`endif
      end else begin
         r_rd_en <= 1'b0;
         r_pass  <= 1'b0;
         r_fail  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!rx_fifo_empty) begin
                  r_rd_en <= 1'b1;
                  r_state <= S_POP;
`ifdef UART_CMD_PARSER_ECHO_EN
                  r_byte  <= rx_fifo_data_out;
`endif
                  if (rx_fifo_data_out == SKIP_CHAR) begin
                     // dropped
                  end else if (rx_fifo_data_out == TERM_CHAR) begin
                     r_term <= 1'b1;
                  end else if (r_count < CW'(CMD_LEN)) begin
                     r_buf[8*r_count +: 8] <= rx_fifo_data_out;
                     r_count               <= r_count + 1'b1;
                  end else begin
                     r_ovf <= 1'b1;
                  end
               end
            end
            S_POP: r_state <= S_GAP;
`ifdef UART_CMD_PARSER_ECHO_EN
            S_GAP: r_state <= S_ECHO;
            S_ECHO: begin
               if (!tx_fifo_full) begin
                  r_state <= r_term ? S_CHECK : S_IDLE;
                  r_pass  <= r_term &  w_match;
                  r_fail  <= r_term & ~w_match;
               end
            end
`else
            S_GAP: begin
               r_state <= r_term ? S_CHECK : S_IDLE;
               r_pass  <= r_term &  w_match;
               r_fail  <= r_term & ~w_match;
            end
`endif
            S_CHECK: begin
               r_term  <= 1'b0;
               r_count <= '0;
               r_ovf   <= 1'b0;
               r_buf   <= '0;
               r_state <= S_RESP;
            end
            S_RESP: if (w_str_done) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_load = (r_state == S_CHECK);

   resp_streamer u_resp (
      .clock   (clock),
      .reset   (reset),
      .i_load  (w_load),
      .i_pass  (r_pass),
      .i_full  (tx_fifo_full),
      .o_data  (w_str_data),
      .o_wr_en (w_str_wr),
      .o_done  (w_str_done)
   );

`ifdef UART_CMD_PARSER_ECHO_EN
   assign tx_fifo_write_en = (r_state == S_ECHO) ? ~tx_fifo_full : w_str_wr;
   assign tx_fifo_data_in  = (r_state == S_ECHO) ? r_byte : w_str_data;
`else
   assign tx_fifo_write_en = w_str_wr;
   assign tx_fifo_data_in  = w_str_data;
`endif

   assign rx_fifo_read_en = r_rd_en;
   assign cmd_pass        = r_pass;
   assign cmd_fail        = r_fail;
   assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: table-driven commands with a TX/result scoreboard,
// plus hand-written backpressure and mid-reply reset sequences.
module tb_uart_cmd_parser;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx_fifo_empty = 1'b1;
   logic [7:0] rx_fifo_data_out = 8'h00;
   logic       tx_fifo_full = 1'b0;
   logic       rx_fifo_read_en;
   logic [7:0] tx_fifo_data_in;
   logic       tx_fifo_write_en;
   logic       cmd_pass;
   logic       cmd_fail;
   logic       busy;

`ifdef UART_CMD_PARSER_ECHO_EN
   localparam int ECHO_ON = 1;
`else
   localparam int ECHO_ON = 0;
`endif
   localparam int LAT = 2 + ECHO_ON;

   always #5 clock = ~clock;

   uart_cmd_parser #(.CMD_LEN(4), .TERM_CHAR(8'h0D), .SKIP_CHAR(8'h0A)) dut (
      .clock            (clock),
      .reset            (reset),
      .rx_fifo_empty    (rx_fifo_empty),
      .rx_fifo_data_out (rx_fifo_data_out),
      .rx_fifo_read_en  (rx_fifo_read_en),
      .tx_fifo_full     (tx_fifo_full),
      .tx_fifo_data_in  (tx_fifo_data_in),
      .tx_fifo_write_en (tx_fifo_write_en),
      .cmd_pass         (cmd_pass),
      .cmd_fail         (cmd_fail),
      .busy             (busy)
   );

   int         n_checks = 0;
   int         n_pass = 0;
   int         cyc = 0;
   int         last_rd_cyc = -100;
   int         pulse_cyc = -100;
   int         last_wr_cyc = -100;
   int         wr_count = 0;
   bit         prev_rd = 1'b0;
   logic [7:0] rxq[$];
   logic [7:0] exp_tx[$];
   bit         exp_res[$];

   typedef struct {
      string  name;
      string  s;
      bit [1:0] res;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic void refresh_rx();
      rx_fifo_empty    = (rxq.size() == 0);
      rx_fifo_data_out = rx_fifo_empty ? 8'h00 : rxq[0];
   endfunction

   // One clock: sample DUT at negedge, model RX FIFO pop, score TX and pulses
   task automatic tick();
      @(negedge clock);
      cyc++;
      if (rx_fifo_read_en) begin
         chk("rd_not_adjacent", {31'd0, prev_rd}, 0);
         if (rxq.size() == 0) chk("rd_while_empty", {31'd0, rx_fifo_empty}, 0);
         else void'(rxq.pop_front());
         last_rd_cyc = cyc;
         refresh_rx();
      end
      prev_rd = rx_fifo_read_en;
      if (tx_fifo_write_en) begin
         chk("wr_while_full", {31'd0, tx_fifo_full}, 0);
         wr_count++;
         last_wr_cyc = cyc;
         if (exp_tx.size() > 0) chk("tx_byte", {24'd0, tx_fifo_data_in}, {24'd0, exp_tx.pop_front()});
         else chk("tx_unexpected", {31'd0, tx_fifo_write_en}, 0);
      end
      if (cmd_pass || cmd_fail) begin
         pulse_cyc = cyc;
         chk("pulse_latency", cyc - last_rd_cyc, LAT);
         if (exp_res.size() > 0) chk("result", {30'd0, cmd_pass, cmd_fail}, exp_res.pop_front() ? 2 : 1);
         else chk("pulse_unexpected", {30'd0, cmd_pass, cmd_fail}, 0);
      end
   endtask

   task automatic push_reply(input bit p);
      string r;
      r = p ? "PASS\015\012" : "FAIL\015\012";
      for (int i = 0; i < 6; i++) exp_tx.push_back(r.getc(i));
   endtask

   // Queue RX bytes and the TX/result expectations they imply
   task automatic push_bytes(input string s, input bit [1:0] res);
      int k = 0;
      for (int i = 0; i < s.len(); i++) begin
         logic [7:0] b;
         b = s.getc(i);
         rxq.push_back(b);
         if (ECHO_ON != 0) exp_tx.push_back(b);
         if (b == 8'h0D) begin
            exp_res.push_back(res[k]);
            push_reply(res[k]);
            k++;
         end
      end
      refresh_rx();
   endtask

   task automatic wait_done(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (exp_tx.size() == 0 && exp_res.size() == 0 && rxq.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk({"done_", name}, {31'd0, ok}, 1);
   endtask

   task automatic wait_writes(input string name, input int target);
      bit hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (wr_count >= target) begin
            hit = 1'b1;
            break;
         end
      end
      chk({"reach_", name}, {31'd0, hit}, 1);
   endtask

   task automatic chk_outputs_zero(input string p);
      chk({p, "_rd_en"}, {31'd0, rx_fifo_read_en}, 0);
      chk({p, "_wr_en"}, {31'd0, tx_fifo_write_en}, 0);
      chk({p, "_tx_data"}, {24'd0, tx_fifo_data_in}, 0);
      chk({p, "_pass"}, {31'd0, cmd_pass}, 0);
      chk({p, "_fail"}, {31'd0, cmd_fail}, 0);
      chk({p, "_busy"}, {31'd0, busy}, 0);
   endtask

   initial begin
      int start;
      vecs[0] = '{"test",      "TEST\015",            2'b01};
      vecs[1] = '{"tset",      "TSET\015",            2'b00};
      vecs[2] = '{"overflow",  "TESTX\015",           2'b00};
      vecs[3] = '{"short",     "TES\015",             2'b00};
      vecs[4] = '{"test_lf",   "TEST\015\012",        2'b01};
      vecs[5] = '{"empty",     "\015",                2'b00};
      vecs[6] = '{"lf_inside", "T\012ES\012T\015",    2'b01};
      vecs[7] = '{"b2b",       "TEST\015\012TEST\015", 2'b11};

      refresh_rx();
      reset = 1'b1;
      repeat (3) tick();
      chk_outputs_zero("reset");
      @(posedge clock); #1 reset = 1'b0;

      for (int v = 0; v < 8; v++) begin
         push_bytes(vecs[v].s, vecs[v].res);
         wait_done(vecs[v].name);
         if (v == 0) chk("reply_span", last_wr_cyc - pulse_cyc, 6);
      end

      // TX full for 10 cycles starting at the second reply byte
      start = wr_count;
      push_bytes("TEST\015", 2'b01);
      wait_writes("bp_first", start + 5*ECHO_ON + 1);
      @(posedge clock); #1 tx_fifo_full = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("wr_held", {31'd0, tx_fifo_write_en}, 0);
      end
      @(posedge clock); #1 tx_fifo_full = 1'b0;
      wait_done("backpressure");

      // Reset after two reply bytes abandons the rest of the reply
      start = wr_count;
      push_bytes("TEST\015", 2'b01);
      wait_writes("rst_two", start + 5*ECHO_ON + 2);
      chk("busy_in_resp", {31'd0, busy}, 1);
      reset = 1'b1;
      exp_tx.delete();
      tick();
      chk_outputs_zero("midreset");
      @(posedge clock); #1 reset = 1'b0;
      push_bytes("TEST\015", 2'b01);
      wait_done("after_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
